// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings for
// memory accesses, FSM state encoding and a funct3 legality helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Encoding values are kept identical to the legacy localparam constants.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WB     = 2'd2
  } state_t;

  // Stores only accept B/H/W; loads additionally accept BU/HU.
  function automatic logic f3_legal(input logic [2:0] funct3, input logic is_store);
    logic legal;
    legal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !is_store;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane alignment for word-addressed memory accesses.
// Ports:
//   funct3, is_store, ea_lo : access size/type and byte offset within the word
//   store_data              : rs2 operand for stores
//   rdata                   : read word from the bus for loads
//   wdata, wstrb            : lane-replicated store data and byte strobes
//   misaligned              : offset not natural for the size, or illegal funct3
//   load_data               : extracted and sign/zero-extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    misaligned = !f3_legal(funct3, is_store);
    // funct3[1:0] carries the access size for both signed and unsigned loads.
    case (funct3[1:0])
      2'b01:   if (ea_lo[0])      misaligned = 1'b1;
      2'b10:   if (ea_lo != 2'b00) misaligned = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wdata = '0;
    wstrb = '0;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          wdata = {4{store_data[7:0]}};
          wstrb = 4'b0001 << ea_lo;
        end
        F3_H: begin
          wdata = {2{store_data[15:0]}};
          wstrb = ea_lo[1] ? 4'b1100 : 4'b0011;
        end
        F3_W: begin
          wdata = store_data;
          wstrb = 4'b1111;
        end
        default: begin
          wdata = '0;
          wstrb = '0;
        end
      endcase
    end
  end

  always_comb begin
    case (ea_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = ea_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'd0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit for the RV32I core; one transaction in flight.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   in_valid/in_ready             : issue handshake (ready only in IDLE)
//   in_is_store, in_funct3        : access type and size
//   in_rs1_data, in_imm           : base and offset forming the effective address
//   in_rs2_data, in_rd_addr       : store data, load destination
//   mem_req/we/addr/wdata/wstrb   : bus request, held until mem_ready
//   mem_ready, mem_rdata          : bus completion and read word
//   rd_addr/rd_write_enable/rd_write_data : register file write port
//   done, misaligned              : retire pulse and fault flag
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [31:0]           in_rs1_data,
  input  logic [31:0]           in_rs2_data,
  input  logic [31:0]           in_imm,
  input  logic [4:0]            in_rd_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic [4:0]            rd_addr,
  output logic                  rd_write_enable,
  output logic [31:0]           rd_write_data,
  output logic                  done,
  output logic                  misaligned
);

  state_t      state;
  logic [2:0]  funct3_q;
  logic        is_store_q;
  logic [1:0]  ea_lo_q;

  logic [31:0] ea;
  logic        idle;
  logic        accept;

  logic [2:0]  a_funct3;
  logic        a_is_store;
  logic [1:0]  a_ea_lo;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic        a_misaligned;
  logic [31:0] a_load_data;

  assign ea       = in_rs1_data + in_imm;
  assign idle     = (state == S_IDLE);
  assign in_ready = idle;
  assign accept   = in_valid && in_ready;

  // A single aligner serves both phases: in IDLE it sees the incoming
  // request (store lanes, fault check); afterwards it sees the latched
  // request so the load path can extract from mem_rdata.
  assign a_funct3   = idle ? in_funct3   : funct3_q;
  assign a_is_store = idle ? in_is_store : is_store_q;
  assign a_ea_lo    = idle ? ea[1:0]     : ea_lo_q;

  lsu_align u_align (
    .funct3     (a_funct3),
    .is_store   (a_is_store),
    .ea_lo      (a_ea_lo),
    .store_data (in_rs2_data),
    .rdata      (mem_rdata),
    .wdata      (a_wdata),
    .wstrb      (a_wstrb),
    .misaligned (a_misaligned),
    .load_data  (a_load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      funct3_q        <= '0;
      is_store_q      <= 1'b0;
      ea_lo_q         <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_wstrb       <= '0;
      rd_addr         <= '0;
      rd_write_enable <= 1'b0;
      rd_write_data   <= '0;
      done            <= 1'b0;
      misaligned      <= 1'b0;
    end else begin
      done            <= 1'b0;
      misaligned      <= 1'b0;
      rd_write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            funct3_q   <= in_funct3;
            is_store_q <= in_is_store;
            ea_lo_q    <= ea[1:0];
            rd_addr    <= in_rd_addr;
            if (a_misaligned) begin
              // Faults retire straight from IDLE without touching the bus.
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state     <= S_ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= in_is_store;
              mem_addr  <= {ea[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= a_wdata;
              mem_wstrb <= a_wstrb;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (is_store_q) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              // Outputs registered here are the ones visible during WB.
              rd_write_data   <= a_load_data;
              rd_write_enable <= (rd_addr != 5'd0);
              done            <= 1'b1;
              state           <= S_WB;
            end
          end
        end
        S_WB: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a transaction-level model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_store = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic [31:0] in_imm = '0;
  logic [4:0]  in_rd_addr = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  rd_addr;
  logic        rd_write_enable;
  logic [31:0] rd_write_data;
  logic        done;
  logic        misaligned;

  lsu #(.ADDR_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_is_store     (in_is_store),
    .in_funct3       (in_funct3),
    .in_rs1_data     (in_rs1_data),
    .in_rs2_data     (in_rs2_data),
    .in_imm          (in_imm),
    .in_rd_addr      (in_rd_addr),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .rd_addr         (rd_addr),
    .rd_write_enable (rd_write_enable),
    .rd_write_data   (rd_write_data),
    .done            (done),
    .misaligned      (misaligned)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;
  int done_exp  = 0;

  // Expected outcome of the transaction currently in flight.
  bit          exp_mis;
  bit          exp_we;
  bit          exp_wen;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [31:0] exp_data;
  logic [4:0]  exp_rd;

  // Values observed for the last transaction, used for literal pins.
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;
  logic [31:0] last_wb_data;
  logic [4:0]  last_rd;
  logic        last_wen;
  logic        last_mis;
  logic        last_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Transaction-level reference: effective address, size, lanes, extension.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [31:0] rdata, input logic [4:0] rd,
                       output bit mis, output logic [31:0] addr,
                       output logic [31:0] wdata, output logic [3:0] wstrb,
                       output logic [31:0] ld, output bit wen);
    logic [31:0] ea, mask, v;
    int unsigned sz, lo;
    int s;
    bit legal;
    ea = rs1 + imm;
    lo = ea % 4;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis = !legal || ((ea % sz) != 0);
    addr = ea & 32'hFFFF_FFFC;
    if (sz == 1)      wdata = (rs2 & 32'hFF) * 32'h0101_0101;
    else if (sz == 2) wdata = (rs2 & 32'hFFFF) * 32'h0001_0001;
    else              wdata = rs2;
    s = ((1 << sz) - 1) << lo;
    wstrb = st ? s[3:0] : 4'b0000;
    v = rdata >> (8 * lo);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v = v & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    ld = v;
    wen = !st && !mis && (rd != 5'd0);
  endtask

  // Compare process: bus outputs whenever a request is up, retire outputs on done.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        check("bus_addr", mem_addr, exp_addr);
        check("bus_we", {31'd0, mem_we}, {31'd0, exp_we});
        check("bus_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
        if (exp_we) check("bus_wdata", mem_wdata, exp_wdata);
        check("wen_during_req", {31'd0, rd_write_enable}, 32'd0);
      end
      if (done) begin
        done_seen++;
        check("retire_misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
        check("retire_wen", {31'd0, rd_write_enable}, {31'd0, exp_wen});
        if (exp_wen) begin
          check("retire_rd", {27'd0, rd_addr}, {27'd0, exp_rd});
          check("retire_data", rd_write_data, exp_data);
        end
      end
    end
  end

  task automatic scramble();
    in_is_store = 1'($urandom);
    in_funct3   = 3'($urandom);
    in_rs1_data = $urandom;
    in_rs2_data = $urandom;
    in_imm      = $urandom;
    in_rd_addr  = 5'($urandom);
  endtask

  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [4:0] rd, input int waits, input logic [31:0] rdata);
    bit wen_b, mis_b;
    @(negedge clk);
    model(st, f3, rs1, rs2, imm, rdata, rd, mis_b, exp_addr, exp_wdata, exp_wstrb, exp_data, wen_b);
    exp_mis = mis_b;
    exp_wen = wen_b;
    exp_we  = st;
    exp_rd  = rd;
    done_exp++;
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_is_store = st; in_funct3 = f3;
    in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm; in_rd_addr = rd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
    last_req = 1'b0;
    if (mis_b) begin
      @(negedge clk);
      check("mis_no_req", {31'd0, mem_req}, 32'd0);
      check("mis_done", {31'd0, done}, 32'd1);
      check("mis_ready", {31'd0, in_ready}, 32'd1);
      last_mis = misaligned;
      last_wen = rd_write_enable;
      return;
    end
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      check("req_held", {31'd0, mem_req}, 32'd1);
      if (w == 0) begin
        last_req = mem_req; last_addr = mem_addr;
        last_wdata = mem_wdata; last_wstrb = mem_wstrb;
      end
      mem_ready = (w == waits);
      mem_rdata = (w == waits) ? rdata : $urandom;
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    @(negedge clk);
    check("done_latency", {31'd0, done}, 32'd1);
    check("req_dropped", {31'd0, mem_req}, 32'd0);
    check("ready_after_done", {31'd0, in_ready}, {31'd0, st});
    last_mis = misaligned;
    last_wen = rd_write_enable;
    last_wb_data = rd_write_data;
    last_rd = rd_addr;
    if (!st) begin
      @(negedge clk);
      check("wb_one_cycle", {31'd0, done}, 32'd0);
      check("ready_after_wb", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    bit m_mis, m_wen;
    logic [31:0] m_addr, m_wdata, m_ld;
    logic [3:0] m_wstrb;

    // Model pins, hand-computed from the lane rules.
    model(1'b0, 3'b000, 32'h1000, 32'h0, 32'h3, 32'h80FF7F01, 5'd3, m_mis, m_addr, m_wdata, m_wstrb, m_ld, m_wen);
    check("pin_model_lb", m_ld, 32'hFFFF_FF80);
    model(1'b1, 3'b001, 32'h2000, 32'h1234ABCD, 32'h2, 32'h0, 5'd0, m_mis, m_addr, m_wdata, m_wstrb, m_ld, m_wen);
    check("pin_model_sh", m_wdata, 32'hABCD_ABCD);
    check("pin_model_sh_strb", {28'd0, m_wstrb}, 32'hC);
    model(1'b0, 3'b101, 32'h1001, 32'h0, 32'h0, 32'h0, 5'd1, m_mis, m_addr, m_wdata, m_wstrb, m_ld, m_wen);
    check("pin_model_hu_mis", {31'd0, m_mis}, 32'd1);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_outputs", {mem_req, mem_we, rd_write_enable, done, misaligned, mem_wstrb, rd_addr},
          32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rd_data", rd_write_data, 32'd0);
    rst = 1'b0;

    // LW, zero-wait bus.
    do_txn(1'b0, 3'b010, 32'h1000, 32'h0, 32'd4, 5'd5, 0, 32'hDEADBEEF);
    check("lw_addr", last_addr, 32'h1004);
    check("lw_data", last_wb_data, 32'hDEADBEEF);
    check("lw_rd", {27'd0, last_rd}, 32'd5);
    check("lw_wen", {31'd0, last_wen}, 32'd1);

    // LB / LBU at ea=0x1003.
    do_txn(1'b0, 3'b000, 32'h1000, 32'h0, 32'd3, 5'd3, 0, 32'h80FF7F01);
    check("lb_data", last_wb_data, 32'hFFFF_FF80);
    do_txn(1'b0, 3'b100, 32'h1000, 32'h0, 32'd3, 5'd3, 1, 32'h80FF7F01);
    check("lbu_data", last_wb_data, 32'h0000_0080);

    // SH with three wait cycles.
    do_txn(1'b1, 3'b001, 32'h2000, 32'h1234ABCD, 32'd2, 5'd9, 3, 32'h0);
    check("sh_addr", last_addr, 32'h2000);
    check("sh_wdata", last_wdata, 32'hABCD_ABCD);
    check("sh_wstrb", {28'd0, last_wstrb}, 32'hC);
    check("sh_no_wen", {31'd0, last_wen}, 32'd0);

    // Misaligned LW.
    do_txn(1'b0, 3'b010, 32'h1000, 32'h0, 32'd2, 5'd7, 0, 32'h0);
    check("lw_mis_flag", {31'd0, last_mis}, 32'd1);
    check("lw_mis_no_req", {31'd0, last_req}, 32'd0);

    // LW to x0: full bus access but no write.
    do_txn(1'b0, 3'b010, 32'h3000, 32'h0, 32'd8, 5'd0, 1, 32'h5555AAAA);
    check("x0_no_wen", {31'd0, last_wen}, 32'd0);
    check("x0_bus_seen", {31'd0, last_req}, 32'd1);

    // Reset during ACCESS.
    @(negedge clk);
    exp_mis = 1'b0; exp_wen = 1'b1; exp_we = 1'b0; exp_rd = 5'd4;
    exp_addr = 32'h4000; exp_wstrb = 4'b0000; exp_wdata = '0; exp_data = '0;
    in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
    in_rs1_data = 32'h4000; in_imm = 32'd0; in_rd_addr = 5'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_req", {31'd0, mem_req}, 32'd0);
    check("async_rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    do_txn(1'b1, 3'b010, 32'h5000, 32'hCAFEF00D, 32'd4, 5'd0, 0, 32'h0);
    check("sw_after_rst_addr", last_addr, 32'h5004);
    check("sw_after_rst_data", last_wdata, 32'hCAFEF00D);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      int off;
      off = int'($urandom_range(0, 63)) - 32;
      do_txn(1'($urandom), 3'($urandom), $urandom, $urandom, off,
             5'($urandom), int'($urandom_range(0, 3)), $urandom);
    end

    repeat (3) @(negedge clk);
    check("done_count", done_seen, done_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
